// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the parametrised register file.
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_REGS   = 32;
    localparam int DEFAULT_NUM_READ   = 2;
    localparam int DEFAULT_NUM_WRITE  = 1;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clear_state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// Sequential clear engine: walks every register index once, then pulses clear_done.
import regfile_pkg::*;

module regfile_clear_seq #(
    parameter int NUM_REGS   = DEFAULT_NUM_REGS,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_req,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic                  clear_we,
    output logic [ADDR_WIDTH-1:0] clear_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

    clear_state_e          state;
    logic [ADDR_WIDTH-1:0] counter;

    // Counter parks at zero outside CLEAR so it never wraps past the last index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= CLR_IDLE;
            counter    <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            case (state)
                CLR_IDLE: begin
                    clear_done <= 1'b0;
                    if (clear_req) begin
                        state      <= CLR_CLEAR;
                        counter    <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                CLR_CLEAR: begin
                    if (counter == LAST_ADDR) begin
                        state      <= CLR_DONE;
                        counter    <= '0;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                CLR_DONE: begin
                    state      <= CLR_IDLE;
                    clear_done <= 1'b0;
                end
                default: begin
                    state      <= CLR_IDLE;
                    counter    <= '0;
                    clear_busy <= 1'b0;
                    clear_done <= 1'b0;
                end
            endcase
        end
    end

    assign clear_we   = clear_busy;
    assign clear_addr = counter;

endmodule

// File: rtl/param_register_file.sv
// N-read / M-write register file with optional zero register, write bypass,
// per-register pending scoreboard and a sequential clear engine.
import regfile_pkg::*;

module param_register_file #(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int NUM_REGS   = DEFAULT_NUM_REGS,
    parameter  int NUM_READ   = DEFAULT_NUM_READ,
    parameter  int NUM_WRITE  = DEFAULT_NUM_WRITE,
    parameter  int ZERO_REG   = 1,
    parameter  int BYPASS     = 1,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]  read_address,
    output logic [NUM_READ-1:0][DATA_WIDTH-1:0]  read_data,
    output logic [NUM_READ-1:0]                  read_pending,
    input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] write_address,
    input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] write_data,
    input  logic [NUM_WRITE-1:0]                 write_enable,
    input  logic                                 reserve_valid,
    input  logic [ADDR_WIDTH-1:0]                reserve_address,
    input  logic                                 clear_req,
    output logic                                 clear_busy,
    output logic                                 clear_done
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic [NUM_REGS-1:0]                 pending;
    logic [NUM_WRITE-1:0]                write_effective;
    logic                                reserve_effective;
    logic                                clear_we;
    logic [ADDR_WIDTH-1:0]               clear_addr;

    regfile_clear_seq #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .clear_we   (clear_we),
        .clear_addr (clear_addr)
    );

    // A write or reservation is dropped while clearing or when it targets the hardwired zero.
    always_comb begin
        write_effective = '0;
        for (int p = 0; p < NUM_WRITE; p++) begin
            write_effective[p] = write_enable[p] && !clear_busy &&
                                 !((ZERO_REG != 0) && (write_address[p] == '0));
        end
        reserve_effective = reserve_valid && !clear_busy &&
                            !((ZERO_REG != 0) && (reserve_address == '0));
    end

    // Later ports overwrite earlier ones, giving the highest index priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '0;
        end else if (clear_we) begin
            regs[clear_addr] <= '0;
        end else begin
            for (int p = 0; p < NUM_WRITE; p++) begin
                if (write_effective[p]) begin
                    regs[write_address[p]] <= write_data[p];
                end
            end
        end
    end

    // Reservation is applied after write-backs so a new producer keeps the bit set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else if (clear_we) begin
            pending[clear_addr] <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_WRITE; p++) begin
                if (write_effective[p]) begin
                    pending[write_address[p]] <= 1'b0;
                end
            end
            if (reserve_effective) begin
                pending[reserve_address] <= 1'b1;
            end
        end
    end

    always_comb begin
        read_data    = '0;
        read_pending = '0;
        for (int r = 0; r < NUM_READ; r++) begin
            read_data[r]    = regs[read_address[r]];
            read_pending[r] = pending[read_address[r]];
            if (BYPASS != 0) begin
                for (int p = 0; p < NUM_WRITE; p++) begin
                    if (write_effective[p] && (write_address[p] == read_address[r])) begin
                        read_data[r] = write_data[p];
                    end
                end
            end
            if ((ZERO_REG != 0) && (read_address[r] == '0)) begin
                read_data[r]    = '0;
                read_pending[r] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_param_register_file.sv
// Randomised and directed bench for param_register_file (2 read / 2 write ports)
// against an array-based reference model.
module tb_param_register_file;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int AW  = 5;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [NRD-1:0][AW-1:0]   read_address;
    logic [NRD-1:0][DW-1:0]   read_data;
    logic [NRD-1:0]           read_pending;
    logic [NWR-1:0][AW-1:0]   write_address;
    logic [NWR-1:0][DW-1:0]   write_data;
    logic [NWR-1:0]           write_enable;
    logic                     reserve_valid;
    logic [AW-1:0]            reserve_address;
    logic                     clear_req;
    logic                     clear_busy;
    logic                     clear_done;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_regs [NR];
    bit            model_pend [NR];
    int            cyc       = 0;
    int            clr_start = -1;

    param_register_file #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .NUM_READ   (NRD),
        .NUM_WRITE  (NWR),
        .ZERO_REG   (1),
        .BYPASS     (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .read_address    (read_address),
        .read_data       (read_data),
        .read_pending    (read_pending),
        .write_address   (write_address),
        .write_data      (write_data),
        .write_enable    (write_enable),
        .reserve_valid   (reserve_valid),
        .reserve_address (reserve_address),
        .clear_req       (clear_req),
        .clear_busy      (clear_busy),
        .clear_done      (clear_done)
    );

    always #5 clk = ~clk;

    // Clear started at edge clr_start occupies the NR cycles after it, then one done cycle.
    function automatic bit modelBusy();
        return (clr_start >= 0) && (cyc >= clr_start) && (cyc < clr_start + NR);
    endfunction

    function automatic bit modelDone();
        return (clr_start >= 0) && (cyc == clr_start + NR);
    endfunction

    function automatic logic [DW-1:0] expRead(input int addr);
        logic [DW-1:0] v;
        if (addr == 0) return '0;
        v = model_regs[addr];
        if (!modelBusy()) begin
            for (int p = 0; p < NWR; p++) begin
                if (write_enable[p] && (int'(write_address[p]) == addr)) v = write_data[p];
            end
        end
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NR; i++) begin
            model_regs[i] = '0;
            model_pend[i] = 1'b0;
        end
        clr_start = -1;
    endtask

    task automatic idleInputs();
        write_enable    = '0;
        write_address   = '0;
        write_data      = '0;
        reserve_valid   = 1'b0;
        reserve_address = '0;
        clear_req       = 1'b0;
    endtask

    task automatic settle();
        #3;
        for (int r = 0; r < NRD; r++) begin
            checkOutput($sformatf("rdata%0d@r%0d", r, read_address[r]), 64'(read_data[r]),
                        64'(expRead(int'(read_address[r]))));
            checkOutput($sformatf("rpend%0d@r%0d", r, read_address[r]), 64'(read_pending[r]),
                        64'(model_pend[read_address[r]]));
        end
        checkOutput("clear_busy", 64'(clear_busy), 64'(modelBusy()));
        checkOutput("clear_done", 64'(clear_done), 64'(modelDone()));
    endtask

    // Apply the rules of one rising edge to the model, using the inputs still held.
    task automatic advance();
        bit busy_now;
        bit idle_now;
        @(posedge clk);
        busy_now = modelBusy();
        idle_now = !busy_now && !modelDone();
        if (busy_now) begin
            model_regs[cyc - clr_start] = '0;
            model_pend[cyc - clr_start] = 1'b0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (write_enable[p] && write_address[p] != 0) begin
                    model_regs[write_address[p]] = write_data[p];
                    model_pend[write_address[p]] = 1'b0;
                end
            end
            if (reserve_valid && reserve_address != 0) model_pend[reserve_address] = 1'b1;
        end
        if (clear_req && idle_now) clr_start = cyc + 1;
        cyc++;
        #1;
    endtask

    task automatic applyStimulus();
        settle();
        advance();
    endtask

    task automatic readAll();
        idleInputs();
        for (int a = 0; a < NR; a++) begin
            read_address[0] = AW'(a);
            read_address[1] = AW'(NR - 1 - a);
            applyStimulus();
        end
    endtask

    initial begin
        int busy_count;
        int done_count;

        idleInputs();
        read_address = '0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", 64'(clear_busy), 64'd0);
        checkOutput("reset done", 64'(clear_done), 64'd0);
        rst = 1'b1;

        readAll();

        // Bypass of a fresh write, then the same value from the array.
        idleInputs();
        write_enable[0] = 1'b1; write_address[0] = 5; write_data[0] = 32'hDEADBEEF;
        read_address[0] = 5; read_address[1] = 5;
        settle();
        checkOutput("bypass r5", 64'(read_data[0]), 64'hDEADBEEF);
        advance();
        idleInputs();
        settle();
        checkOutput("array r5", 64'(read_data[1]), 64'hDEADBEEF);
        advance();

        // Zero register ignores writes.
        write_enable[0] = 1'b1; write_address[0] = 0; write_data[0] = 32'h1234;
        read_address[0] = 0;
        settle();
        checkOutput("r0 bypass", 64'(read_data[0]), 64'd0);
        advance();
        idleInputs();
        settle();
        checkOutput("r0 array", 64'(read_data[0]), 64'd0);
        advance();

        // Same-address dual write: port 1 wins.
        write_enable = 2'b11; write_address[0] = 7; write_address[1] = 7;
        write_data[0] = 32'h11; write_data[1] = 32'h22;
        read_address[0] = 7; read_address[1] = 7;
        settle();
        checkOutput("r7 bypass prio", 64'(read_data[0]), 64'h22);
        advance();
        idleInputs();
        settle();
        checkOutput("r7 array prio", 64'(read_data[1]), 64'h22);
        advance();

        // Scoreboard set, clear, and reserve-beats-write.
        reserve_valid = 1'b1; reserve_address = 3; read_address[0] = 3;
        applyStimulus();
        idleInputs();
        settle();
        checkOutput("r3 reserved", 64'(read_pending[0]), 64'd1);
        advance();
        write_enable[0] = 1'b1; write_address[0] = 3; write_data[0] = 32'hA5;
        applyStimulus();
        idleInputs();
        settle();
        checkOutput("r3 written", 64'(read_pending[0]), 64'd0);
        advance();
        write_enable[0] = 1'b1; write_address[0] = 3; write_data[0] = 32'h5A;
        reserve_valid = 1'b1; reserve_address = 3;
        applyStimulus();
        idleInputs();
        settle();
        checkOutput("r3 res+write", 64'(read_pending[0]), 64'd1);
        advance();

        // Fill, pend r9, then a full clear with a write attempted mid-clear.
        for (int i = 1; i < NR; i++) begin
            idleInputs();
            write_enable[0] = 1'b1; write_address[0] = AW'(i); write_data[0] = $urandom | 32'h1;
            read_address[0] = AW'($urandom_range(0, NR - 1));
            read_address[1] = AW'(i);
            applyStimulus();
        end
        idleInputs();
        reserve_valid = 1'b1; reserve_address = 9; read_address[0] = 9;
        applyStimulus();
        idleInputs();
        clear_req = 1'b1;
        applyStimulus();
        clear_req = 1'b0;
        busy_count = 0;
        done_count = 0;
        for (int k = 0; k <= NR + 1; k++) begin
            idleInputs();
            if (k == 3) begin
                write_enable[0] = 1'b1; write_address[0] = 4; write_data[0] = 32'hBAD0BAD0;
            end
            read_address[0] = 4;
            read_address[1] = AW'($urandom_range(0, NR - 1));
            settle();
            if (clear_busy) busy_count++;
            if (clear_done) done_count++;
            advance();
        end
        checkOutput("busy length", 64'(busy_count), 64'(NR));
        checkOutput("done pulses", 64'(done_count), 64'd1);
        readAll();

        // Reset asserted while the clear counter sits at 10.
        for (int i = 10; i <= 20; i++) begin
            idleInputs();
            write_enable[1] = 1'b1; write_address[1] = AW'(i); write_data[1] = $urandom | 32'h1;
            reserve_valid = (i == 20); reserve_address = 25;
            applyStimulus();
        end
        idleInputs();
        clear_req = 1'b1;
        applyStimulus();
        clear_req = 1'b0;
        repeat (10) applyStimulus();
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midclear busy", 64'(clear_busy), 64'd0);
        checkOutput("midclear done", 64'(clear_done), 64'd0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        readAll();

        // Randomised traffic with occasional clears.
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NWR; p++) begin
                write_enable[p]  = 1'($urandom_range(0, 1));
                write_address[p] = AW'($urandom_range(0, 7));
                write_data[p]    = $urandom;
            end
            reserve_valid   = 1'($urandom_range(0, 1));
            reserve_address = AW'($urandom_range(0, 7));
            clear_req       = ($urandom_range(0, 63) == 0);
            for (int r = 0; r < NRD; r++) begin
                if ($urandom_range(0, 1) == 1) read_address[r] = write_address[$urandom_range(0, NWR - 1)];
                else read_address[r] = AW'($urandom_range(0, NR - 1));
            end
            applyStimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
